pin_entry_verifier: RTL and testbench



---
 rtl/atm_pkg.sv | 25 ++
 rtl/pin_digit_buffer.sv | 35 +++
 rtl/pin_entry_verifier.sv | 133 +++++++++++++
 tb/tb_pin_entry_verifier.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Definitions shared by the ATM session stages: PIN FSM states, default PIN
// parameters and the controller's operation codes.
package atm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_CHECK   = 3'd2,
        ST_GRANTED = 3'd3,
        ST_LOCKED  = 3'd4
    } pin_state_t;

    localparam int BCD_MAX                = 9;
    localparam int DEFAULT_PIN_DIGITS     = 4;
    localparam int DEFAULT_MAX_TRIES      = 3;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1000;

    typedef enum logic [1:0] {
        OP_NONE     = 2'b00,
        OP_BALANCE  = 2'b01,
        OP_DEPOSIT  = 2'b10,
        OP_WITHDRAW = 2'b11
    } op_code_t;

endpackage

// File: rtl/pin_digit_buffer.sv
// Shift register collecting BCD digits most-significant first, with a digit
// counter that saturates at DIGITS.
module pin_digit_buffer
    import atm_pkg::*;
#(
    parameter int DIGITS = DEFAULT_PIN_DIGITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  shift,
    input  logic [3:0]            digit_in,
    output logic [3:0]            count,
    output logic                  full,
    output logic [4*DIGITS-1:0]   value
);

    logic [4*DIGITS-1:0] digit_ext;

    assign digit_ext = (4*DIGITS)'(digit_in);
    assign full      = (count == 4'(DIGITS));

    // NOTE: the buffer holds a secret, so it is reset and cleared like any
    // control register rather than left to power up undefined.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            value <= '0;
            count <= '0;
        end else if (shift && !full) begin
            value <= (value << 4) | digit_ext;
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/pin_entry_verifier.sv
// Collects keypad digits, compares them with the card PIN, counts failures,
// enforces keypad inactivity timeout and locks the card after MAX_TRIES.
module pin_entry_verifier
    import atm_pkg::*;
#(
    parameter int PIN_DIGITS     = DEFAULT_PIN_DIGITS,
    parameter int MAX_TRIES      = DEFAULT_MAX_TRIES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cardIn,
    input  logic [4*PIN_DIGITS-1:0] card_pin,
    input  logic                    digit_valid,
    input  logic [3:0]              digit,
    input  logic                    digit_clear,
    input  logic                    session_end,
    output logic                    correctPassword,
    output logic                    pin_wrong,
    output logic                    entry_timeout,
    output logic                    card_locked,
    output logic [3:0]              digits_entered,
    output logic [2:0]              tries_left
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    pin_state_t              state;
    logic [4*PIN_DIGITS-1:0] pin_ref;
    logic [4*PIN_DIGITS-1:0] entry;
    logic [2:0]              failures;
    logic [TW-1:0]           timer;
    logic                    buf_full;
    logic                    buf_clear;
    logic                    buf_shift;
    logic                    key_ok;
    logic                    timeout_hit;

    assign key_ok      = digit_valid && (digit <= 4'(BCD_MAX));
    assign timeout_hit = (state == ST_COLLECT) && cardIn && !digit_clear && !key_ok &&
                         (digits_entered != 4'd0) && (timer == TW'(TIMEOUT_CYCLES - 1));

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        buf_clear = 1'b0;
        buf_shift = 1'b0;
        case (state)
            ST_IDLE:    buf_clear = 1'b1;
            ST_COLLECT: begin
                if (!cardIn || digit_clear || timeout_hit) buf_clear = 1'b1;
                else if (key_ok)                           buf_shift = 1'b1;
            end
            ST_CHECK:   buf_clear = 1'b1;
            default:    ;
        endcase
    end

    pin_digit_buffer #(.DIGITS(PIN_DIGITS)) u_buffer (
        .clk      (clk),
        .reset    (reset),
        .clear    (buf_clear),
        .shift    (buf_shift),
        .digit_in (digit),
        .count    (digits_entered),
        .full     (buf_full),
        .value    (entry)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            pin_ref       <= '0;
            failures      <= '0;
            timer         <= '0;
            tries_left    <= 3'(MAX_TRIES);
            pin_wrong     <= 1'b0;
            entry_timeout <= 1'b0;
        end else begin
            pin_wrong     <= 1'b0;
            entry_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    timer <= '0;
                    if (cardIn) begin
                        pin_ref    <= card_pin;
                        failures   <= '0;
                        tries_left <= 3'(MAX_TRIES);
                        state      <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (!cardIn) begin
                        timer <= '0;
                        state <= ST_IDLE;
                    end else if (digit_clear || digits_entered == 4'd0 && !key_ok) begin
                        timer <= '0;
                    end else if (key_ok) begin
                        timer <= '0;
                        if (digits_entered == 4'(PIN_DIGITS - 1)) state <= ST_CHECK;
                    end else if (timeout_hit) begin
                        timer         <= '0;
                        entry_timeout <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (entry == pin_ref) begin
                        state <= ST_GRANTED;
                    end else begin
                        failures   <= failures + 3'd1;
                        tries_left <= tries_left - 3'd1;
                        pin_wrong  <= 1'b1;
                        state      <= (failures == 3'(MAX_TRIES - 1)) ? ST_LOCKED : ST_COLLECT;
                    end
                end
                ST_GRANTED: begin
                    if (session_end || !cardIn) state <= ST_IDLE;
                end
                ST_LOCKED: begin
                    tries_left <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign correctPassword = (state == ST_GRANTED);
    assign card_locked     = (state == ST_LOCKED);

endmodule

// File: tb/tb_pin_entry_verifier.sv
// Directed bench for pin_entry_verifier: grant, retry, lockout, clear,
// inactivity timeout, abort and reset-in-CHECK.
module tb_pin_entry_verifier;

    logic        clk = 1'b0;
    logic        reset;
    logic        cardIn;
    logic [15:0] card_pin;
    logic        digit_valid;
    logic [3:0]  digit;
    logic        digit_clear;
    logic        session_end;
    logic        correctPassword;
    logic        pin_wrong;
    logic        entry_timeout;
    logic        card_locked;
    logic [3:0]  digits_entered;
    logic [2:0]  tries_left;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pin_entry_verifier #(
        .PIN_DIGITS     (4),
        .MAX_TRIES      (3),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cardIn          (cardIn),
        .card_pin        (card_pin),
        .digit_valid     (digit_valid),
        .digit           (digit),
        .digit_clear     (digit_clear),
        .session_end     (session_end),
        .correctPassword (correctPassword),
        .pin_wrong       (pin_wrong),
        .entry_timeout   (entry_timeout),
        .card_locked     (card_locked),
        .digits_entered  (digits_entered),
        .tries_left      (tries_left)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        digit_valid = 1'b1;
        digit       = d;
        step();
        digit_valid = 1'b0;
        digit       = 4'd0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; cardIn = 1'b0; card_pin = 16'h1234;
        digit_valid = 1'b0; digit = 4'd0; digit_clear = 1'b0; session_end = 1'b0;
        step(); step();
        check("rst_cp",     correctPassword, 0);
        check("rst_wrong",  pin_wrong, 0);
        check("rst_tmo",    entry_timeout, 0);
        check("rst_lock",   card_locked, 0);
        check("rst_digits", digits_entered, 0);
        check("rst_tries",  tries_left, 3);
        reset = 1'b0;

        // Correct PIN on first attempt
        cardIn = 1'b1; step();
        key(4'd1); check("m_d1", digits_entered, 1);
        key(4'd2); check("m_d2", digits_entered, 2);
        key(4'd3); check("m_d3", digits_entered, 3);
        key(4'd4); check("m_check_cp", correctPassword, 0);
        step();
        check("m_cp",    correctPassword, 1);
        check("m_tries", tries_left, 3);
        session_end = 1'b1; step(); session_end = 1'b0;
        check("m_end_cp", correctPassword, 0);

        // Wrong PIN, then correct PIN
        step();
        key(4'd1); key(4'd2); key(4'd3); key(4'd5);
        check("w_check_pw", pin_wrong, 0);
        step();
        check("w_pw",     pin_wrong, 1);
        check("w_tries",  tries_left, 2);
        check("w_digits", digits_entered, 0);
        key(4'd1);
        check("w_pw_pulse", pin_wrong, 0);
        key(4'd2); key(4'd3); key(4'd4); step();
        check("w_cp",      correctPassword, 1);
        check("w_cp_tries", tries_left, 2);
        cardIn = 1'b0; step();
        check("w_eject_cp", correctPassword, 0);

        // Lockout after three wrong PINs
        cardIn = 1'b1; step();
        check("l_tries0", tries_left, 3);
        for (int a = 0; a < 3; a++) begin
            key(4'd9); key(4'd9); key(4'd9); key(4'd9); step();
            check("l_pw",    pin_wrong, 1);
            check("l_tries", tries_left, 3'(2 - a));
            check("l_lock",  card_locked, (a == 2) ? 1 : 0);
        end
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        cardIn = 1'b0; step(); step();
        check("l_hold_lock",   card_locked, 1);
        check("l_hold_tries",  tries_left, 0);
        check("l_hold_digits", digits_entered, 0);
        check("l_hold_cp",     correctPassword, 0);
        reset = 1'b1; step(); reset = 1'b0;
        check("l_rst_lock",  card_locked, 0);
        check("l_rst_tries", tries_left, 3);
        check("l_rst_pw",    pin_wrong, 0);

        // Invalid key and clear
        cardIn = 1'b1; step();
        key(4'd1); key(4'd2);
        check("c_two", digits_entered, 2);
        key(4'hB);
        check("c_invalid", digits_entered, 2);
        digit_clear = 1'b1; key(4'd7); digit_clear = 1'b0;
        check("c_clear", digits_entered, 0);
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); step();
        check("c_cp", correctPassword, 1);
        cardIn = 1'b0; step();

        // Inactivity timeout
        cardIn = 1'b1; step();
        key(4'd1);
        check("t_d1", digits_entered, 1);
        for (int i = 0; i < 7; i++) step();
        check("t_early_tmo",    entry_timeout, 0);
        check("t_early_digits", digits_entered, 1);
        step();
        check("t_tmo",    entry_timeout, 1);
        check("t_digits", digits_entered, 0);
        check("t_tries",  tries_left, 3);
        step();
        check("t_tmo_pulse", entry_timeout, 0);

        // Abort by card removal, then reset during CHECK
        key(4'd1); key(4'd2);
        check("a_two", digits_entered, 2);
        cardIn = 1'b0; step();
        check("a_abort_digits", digits_entered, 0);
        cardIn = 1'b1; step();
        key(4'd9); key(4'd9); key(4'd9); key(4'd9);
        reset = 1'b1; step(); reset = 1'b0;
        check("r_pw",     pin_wrong, 0);
        check("r_digits", digits_entered, 0);
        check("r_tries",  tries_left, 3);
        check("r_cp",     correctPassword, 0);
        step();
        check("r_pw_late", pin_wrong, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
